exp_lut_arbiter: RTL and testbench
==================================

# exp_lut_arbiter

- Shares one dual-port, 1-cycle-latency exponent lookup ROM (dual_port_ram_pos-style) among NUM_REQ SFU lanes.
- Each cycle it grants up to two lane requests in round-robin order, one on LUT port A and one on port B.
- It tracks which lane owns each in-flight read and returns registered lookup results to that lane.
- It sits between the SFU lane front-ends and the LUT instance.

## Interface
- NUM_REQ, 4: number of requesting lanes; 2..16.
- ADDR_WIDTH, 5: LUT address width.
- DATA_WIDTH, 20: LUT data width.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous, active-high. The integrator drives the LUT's rst_n from ~rst.
- req_valid  in  NUM_REQ  per-lane lookup request.
- req_addr  in  NUM_REQ*ADDR_WIDTH  per-lane address; lane i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready  out  NUM_REQ  per-lane grant; combinational from req_valid and the round-robin pointer.
- resp_valid  out  NUM_REQ  per-lane result strobe; one cycle; no backpressure.
- resp_data  out  NUM_REQ*DATA_WIDTH  per-lane result; held between strobes.
- lut_en  out  1  LUT read enable.
- lut_addr_a, lut_addr_b  out  ADDR_WIDTH  LUT port addresses.
- lut_q_a, lut_q_b  in  DATA_WIDTH  LUT port outputs, valid one cycle after lut_en.
- grant_cnt  out  16  total accepted requests; saturates at 0xFFFF.

## Operation
**Handshake**
- A request transfers when req_valid[i] && req_ready[i].
- The lane holds req_valid and req_addr stable until the transfer.
- req_ready[i] is never asserted without req_valid[i].

**Arbitration**
- Scan lanes starting at rr_ptr, wrapping modulo NUM_REQ.
- The first valid lane found is granted port A; the second is granted port B.
- Any further valid lanes wait.
- If at least one lane is granted, rr_ptr becomes (index of the last granted lane + 1) mod NUM_REQ. Otherwise rr_ptr is unchanged.
- Consequence: with all lanes always valid, every lane is granted at least once per ceil(NUM_REQ/2) cycles.

**LUT drive (combinational)**
- lut_en = any grant this cycle.
- lut_addr_a = address of the port-A grantee, else 0.
- lut_addr_b = address of the port-B grantee, else 0.
- Two lanes with the same address are each served independently.

**Tag pipeline**
- Stage-1 registers capture {va, ida, vb, idb} on the grant cycle.
- va and vb are cleared when there is no grant.
- In the following cycle, when va=1: resp_data[ida] <= lut_q_a and resp_valid[ida] <= 1. Port B is handled the same way via vb/idb and lut_q_b.
- All other resp_valid bits are 0 that cycle.

**Counter**
- grant_cnt adds the number of grants this cycle (0, 1 or 2), saturating at 0xFFFF.

## Timing
- Latency: request accepted in cycle T; LUT read at edge T+1; resp_valid and resp_data registered at edge T+2, i.e. visible in cycle T+2.
- Throughput: 2 lookups per cycle, fully pipelined, with no bubbles under back-to-back grants.
- Reset values: rr_ptr=0, va=vb=0, resp_valid=0, resp_data=0, grant_cnt=0.
- During rst, req_ready=0 and lut_en=0.
- Reset mid-operation: in-flight lookups are dropped and no resp_valid is produced for them. The first grant possible is the cycle after rst deasserts.
- Because the LUT holds its output when lut_en=0, a stale lut_q is never forwarded: va/vb gate all forwarding.
- Single valid lane: it gets port A; port B is idle with vb=0.
- Wrap-around: with rr_ptr=NUM_REQ-1 and lanes NUM_REQ-1 and 0 valid, A goes to lane NUM_REQ-1, B goes to lane 0, and rr_ptr becomes 1.
- A lane may re-request in the cycle right after its grant. Responses always return in grant order per lane.

## Test plan
- Reset: assert rst for 3 cycles with all req_valid=1. Required: req_ready=0, lut_en=0, resp_valid=0, grant_cnt=0 throughout.
- Single lookup: lane 2 requests addr 16 at cycle T. Required: req_ready[2]=1 at T, lut_addr_a=16, resp_valid[2]=1 with resp_data=0x160C at T+2, grant_cnt=1.
- Dual grant: lanes 0 and 3 request addrs 0 and 31 at rr_ptr=0. Required: A→lane 0, B→lane 3; resp 0x0267 on lane 0 and 0x0004 on lane 3, in the same cycle; rr_ptr=0 afterwards.
- Fairness: all 4 lanes continuously valid for 8 cycles (NUM_REQ=4). Required: grant pairs (0,1),(2,3),(0,1),… and exactly 4 grants per lane; grant_cnt=16.
- Reset mid-flight: grant lanes 1 and 2 at T, assert rst at T+1. Required: no resp_valid at T+2, rr_ptr=0 after reset.
- Saturation: preload grant_cnt to 0xFFFE via 32767 dual-grant cycles, then one more dual grant. Required: grant_cnt=0xFFFF and it stays there.

Source files
------------

// File: rtl/exp_lut_arbiter.sv
// -----------------------------------------------------------------------------
// exp_lut_arbiter
//   Shares one dual-port exponent LUT (1-cycle read latency) among NUM_REQ SFU
//   lanes. Up to two requests are granted per cycle in round-robin order: the
//   first valid lane found from rr_ptr gets port A, the second gets port B.
//   The owning lane of each in-flight read is tagged through one register
//   stage, and the LUT result is registered into that lane's response slot.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   req_valid_i/_addr_i  per-lane lookup request (lane i at [i*AW +: AW])
//   req_ready_o          per-lane grant, combinational
//   resp_valid_o/_data_o per-lane result strobe / held result
//   lut_en_o, lut_addr_a_o, lut_addr_b_o   LUT read drive
//   lut_q_a_i, lut_q_b_i                   LUT outputs, one cycle after lut_en
//   grant_cnt_o          saturating count of accepted requests
// -----------------------------------------------------------------------------

// Per-lane response register: loads from whichever port was tagged for this
// lane. The arbiter never tags both ports with the same lane.
module exp_lut_resp_lane #(
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hit_a_i,
    input  logic                  hit_b_i,
    input  logic [DATA_WIDTH-1:0] q_a_i,
    input  logic [DATA_WIDTH-1:0] q_b_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o
);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
        end else begin
            valid_o <= hit_a_i | hit_b_i;
            if (hit_a_i)      data_o <= q_a_i;
            else if (hit_b_i) data_o <= q_b_i;
        end
    end
endmodule

module exp_lut_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 20
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic [NUM_REQ-1:0]            resp_valid_o,
    output logic [NUM_REQ*DATA_WIDTH-1:0] resp_data_o,
    output logic                          lut_en_o,
    output logic [ADDR_WIDTH-1:0]         lut_addr_a_o,
    output logic [ADDR_WIDTH-1:0]         lut_addr_b_o,
    input  logic [DATA_WIDTH-1:0]         lut_q_a_i,
    input  logic [DATA_WIDTH-1:0]         lut_q_b_i,
    output logic [15:0]                   grant_cnt_o
);
    localparam int IDW = $clog2(NUM_REQ);

    // (base + off) mod NUM_REQ, for base < NUM_REQ and off < NUM_REQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
        logic [IDW:0] s;
        s = {1'b0, base} + (IDW+1)'(off);
        if (s >= (IDW+1)'(NUM_REQ)) s = s - (IDW+1)'(NUM_REQ);
        return s[IDW-1:0];
    endfunction

    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
    assign addr_v = req_addr_i;

    logic [IDW-1:0] rr_ptr_q;
    logic           gnt_a, gnt_b;
    logic [IDW-1:0] id_a, id_b, idx;

    // Round-robin scan from rr_ptr; nothing is granted while in reset.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        id_a  = '0;
        id_b  = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_add(rr_ptr_q, k);
            if (req_valid_i[idx] && !rst_i) begin
                if (!gnt_a) begin
                    gnt_a = 1'b1;
                    id_a  = idx;
                end else if (!gnt_b) begin
                    gnt_b = 1'b1;
                    id_b  = idx;
                end
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (gnt_a) req_ready_o[id_a] = 1'b1;
        if (gnt_b) req_ready_o[id_b] = 1'b1;
    end

    assign lut_en_o     = gnt_a;   // port B is only used when A is
    assign lut_addr_a_o = gnt_a ? addr_v[id_a] : '0;
    assign lut_addr_b_o = gnt_b ? addr_v[id_b] : '0;

    // Pointer moves past the last lane granted this cycle.
    logic [IDW-1:0] last_id;
    assign last_id = gnt_b ? id_b : id_a;

    logic [1:0]  n_gnt;
    logic [16:0] cnt_sum;
    logic [15:0] grant_cnt_q;
    assign n_gnt   = {1'b0, gnt_a} + {1'b0, gnt_b};
    assign cnt_sum = {1'b0, grant_cnt_q} + 17'(n_gnt);

    // Tag stage: which lane owns the read currently inside the LUT.
    logic           va_q, vb_q;
    logic [IDW-1:0] ida_q, idb_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
            va_q        <= 1'b0;
            vb_q        <= 1'b0;
            ida_q       <= '0;
            idb_q       <= '0;
        end else begin
            if (gnt_a) rr_ptr_q <= wrap_add(last_id, 1);
            grant_cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
            va_q        <= gnt_a;
            vb_q        <= gnt_b;
            ida_q       <= id_a;
            idb_q       <= id_b;
        end
    end

    assign grant_cnt_o = grant_cnt_q;

    // va/vb gate forwarding so a held (stale) LUT output is never returned.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
        logic hit_a, hit_b;
        assign hit_a = va_q && (ida_q == IDW'(g));
        assign hit_b = vb_q && (idb_q == IDW'(g));
        exp_lut_resp_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .hit_a_i (hit_a),
            .hit_b_i (hit_b),
            .q_a_i   (lut_q_a_i),
            .q_b_i   (lut_q_b_i),
            .valid_o (resp_valid_o[g]),
            .data_o  (resp_data_o[g*DATA_WIDTH +: DATA_WIDTH])
        );
    end
endmodule

// File: tb/tb_exp_lut_arbiter.sv
module tb_exp_lut_arbiter;
    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      resp_valid;
    logic [N*DW-1:0]   resp_data;
    logic              lut_en;
    logic [AW-1:0]     lut_addr_a, lut_addr_b;
    logic [DW-1:0]     lut_q_a = '0;
    logic [DW-1:0]     lut_q_b = '0;
    logic [15:0]       grant_cnt;

    int errors = 0;
    int checks = 0;

    exp_lut_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_addr_i(req_addr), .req_ready_o(req_ready),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data),
        .lut_en_o(lut_en), .lut_addr_a_o(lut_addr_a), .lut_addr_b_o(lut_addr_b),
        .lut_q_a_i(lut_q_a), .lut_q_b_i(lut_q_b), .grant_cnt_o(grant_cnt)
    );

    always #5 clk = ~clk;

    // LUT model: registered read, output held when not enabled.
    logic [DW-1:0] rom [32];
    always @(posedge clk) if (lut_en) begin
        lut_q_a <= rom[lut_addr_a];
        lut_q_b <= rom[lut_addr_b];
    end

    // Reference model state (values visible in the current cycle).
    int                m_ptr, m_cnt;
    logic [N-1:0]      m_rv;
    logic [N-1:0][DW-1:0] m_rd;
    int                pa_lane, pb_lane;
    logic [AW-1:0]     pa_addr, pb_addr;
    // Expected combinational outputs of the current cycle.
    int                ga, gb;
    logic [N-1:0]      exp_ready;
    logic              exp_en;
    logic [AW-1:0]     exp_aa, exp_ab;

    function automatic logic [AW-1:0] lane_addr(input int l);
        return req_addr[l*AW +: AW];
    endfunction

    task automatic set_addr(input int l, input logic [AW-1:0] a);
        req_addr[l*AW +: AW] = a;
    endtask

    // Sample point: compute the grants the rules call for this cycle.
    task automatic eval();
        @(negedge clk);
        ga = -1; gb = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int l;
                l = (m_ptr + k) % N;
                if (req_valid[l]) begin
                    if (ga < 0) ga = l;
                    else if (gb < 0) gb = l;
                end
            end
        end
        exp_ready = '0;
        if (ga >= 0) exp_ready[ga] = 1'b1;
        if (gb >= 0) exp_ready[gb] = 1'b1;
        exp_en = (ga >= 0);
        exp_aa = (ga >= 0) ? lane_addr(ga) : '0;
        exp_ab = (gb >= 0) ? lane_addr(gb) : '0;
    endtask

    // Commit the cycle into the model and move to just after the next edge.
    task automatic advance();
        if (rst) begin
            m_ptr = 0; m_cnt = 0; m_rv = '0; m_rd = '0;
            pa_lane = -1; pb_lane = -1;
        end else begin
            m_rv = '0;
            if (pa_lane >= 0) begin m_rv[pa_lane] = 1'b1; m_rd[pa_lane] = rom[pa_addr]; end
            if (pb_lane >= 0) begin m_rv[pb_lane] = 1'b1; m_rd[pb_lane] = rom[pb_addr]; end
            pa_lane = ga; pa_addr = exp_aa;
            pb_lane = gb; pb_addr = exp_ab;
            m_cnt = m_cnt + (ga >= 0 ? 1 : 0) + (gb >= 0 ? 1 : 0);
            if (m_cnt > 65535) m_cnt = 65535;
            if (ga >= 0) m_ptr = ((gb >= 0 ? gb : ga) + 1) % N;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        for (int l = 0; l < N; l++) set_addr(l, AW'($urandom_range(31)));
        m_ptr = 0; m_cnt = 0; m_rv = '0; m_rd = '0; pa_lane = -1; pb_lane = -1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            eval();
            checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready c%0d: got %b want 0", c, req_ready); end
            checks++; if (lut_en !== 1'b0) begin errors++; $display("FAIL reset_lut_en c%0d: got %b want 0", c, lut_en); end
            checks++; if (resp_valid !== '0) begin errors++; $display("FAIL reset_resp_valid c%0d: got %b want 0", c, resp_valid); end
            checks++; if (grant_cnt !== 16'd0) begin errors++; $display("FAIL reset_grant_cnt c%0d: got %h want 0", c, grant_cnt); end
            checks++; if (resp_data !== '0) begin errors++; $display("FAIL reset_resp_data c%0d: got %h want 0", c, resp_data); end
            advance();
        end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        set_addr(2, 5'd16);
        eval();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        checks++; if (lut_en !== 1'b1 || lut_addr_a !== 5'd16) begin errors++; $display("FAIL single_lut: got en=%b a=%0d want en=1 a=16", lut_en, lut_addr_a); end
        advance();
        req_valid = '0;
        eval(); advance();
        eval();
        checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp_valid: got %b want 0100", resp_valid); end
        checks++; if (resp_data[2*DW +: DW] !== 20'h0160C) begin errors++; $display("FAIL single_resp_data: got %h want 0160c", resp_data[2*DW +: DW]); end
        checks++; if (grant_cnt !== 16'd1) begin errors++; $display("FAIL single_grant_cnt: got %0d want 1", grant_cnt); end
        advance();
    endtask

    task automatic test_dual();
        // Lane 3 alone moves the pointer back to 0.
        req_valid = 4'b1000;
        eval();
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL dual_prep_ready: got %b want 1000", req_ready); end
        advance();
        req_valid = 4'b1001;
        set_addr(0, 5'd0);
        set_addr(3, 5'd31);
        eval();
        checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL dual_ready: got %b want 1001", req_ready); end
        checks++; if (lut_addr_a !== 5'd0 || lut_addr_b !== 5'd31) begin errors++; $display("FAIL dual_lut_addr: got a=%0d b=%0d want a=0 b=31", lut_addr_a, lut_addr_b); end
        advance();
        req_valid = '0;
        eval(); advance();
        eval();
        checks++; if (resp_valid !== 4'b1001) begin errors++; $display("FAIL dual_resp_valid: got %b want 1001", resp_valid); end
        checks++; if (resp_data[0 +: DW] !== 20'h00267 || resp_data[3*DW +: DW] !== 20'h00004) begin
            errors++; $display("FAIL dual_resp_data: got l0=%h l3=%h want 00267 00004", resp_data[0 +: DW], resp_data[3*DW +: DW]);
        end
        advance();
    endtask

    task automatic test_fairness();
        int cnt [N];
        logic [N-1:0] want;
        for (int l = 0; l < N; l++) cnt[l] = 0;
        req_valid = '1;
        for (int c = 0; c < 8; c++) begin
            eval();
            want = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            checks++; if (req_ready !== want) begin errors++; $display("FAIL fair_ready c%0d: got %b want %b", c, req_ready, want); end
            checks++; if (resp_valid !== m_rv || resp_data !== m_rd) begin errors++; $display("FAIL fair_resp c%0d: got %b/%h want %b/%h", c, resp_valid, resp_data, m_rv, m_rd); end
            for (int l = 0; l < N; l++) if (req_ready[l]) cnt[l]++;
            advance();
        end
        req_valid = '0;
        eval();
        for (int l = 0; l < N; l++) begin
            checks++; if (cnt[l] != 4) begin errors++; $display("FAIL fair_count lane%0d: got %0d want 4", l, cnt[l]); end
        end
        // 4 grants from the earlier directed tests plus 16 here.
        checks++; if (grant_cnt !== 16'd20) begin errors++; $display("FAIL fair_grant_cnt: got %0d want 20", grant_cnt); end
        advance();
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b0110;
        eval();
        checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL mid_ready: got %b want 0110", req_ready); end
        advance();
        req_valid = '0;
        rst = 1'b1;
        eval();
        checks++; if (req_ready !== '0 || lut_en !== 1'b0) begin errors++; $display("FAIL mid_rst_drive: got rdy=%b en=%b want 0 0", req_ready, lut_en); end
        advance();
        rst = 1'b0;
        req_valid = '1;
        eval();
        checks++; if (resp_valid !== '0) begin errors++; $display("FAIL mid_no_resp: got %b want 0", resp_valid); end
        checks++; if (req_ready !== 4'b0011) begin errors++; $display("FAIL mid_ptr_reset: got %b want 0011", req_ready); end
        checks++; if (grant_cnt !== 16'd0) begin errors++; $display("FAIL mid_grant_cnt: got %0d want 0", grant_cnt); end
        advance();
        req_valid = '0;
    endtask

    task automatic test_wrap();
        // Pointer is 2 here; lane 2 alone moves it to 3.
        req_valid = 4'b0100;
        eval(); advance();
        req_valid = 4'b1001;
        set_addr(3, 5'd7);
        set_addr(0, 5'd9);
        eval();
        checks++; if (lut_addr_a !== 5'd7 || lut_addr_b !== 5'd9) begin errors++; $display("FAIL wrap_lut_addr: got a=%0d b=%0d want a=7 b=9", lut_addr_a, lut_addr_b); end
        checks++; if (req_ready !== 4'b1001) begin errors++; $display("FAIL wrap_ready: got %b want 1001", req_ready); end
        advance();
        req_valid = '1;
        eval();
        checks++; if (req_ready !== 4'b0110) begin errors++; $display("FAIL wrap_ptr: got %b want 0110", req_ready); end
        advance();
        req_valid = '0;
        eval();
        checks++; if (resp_valid !== m_rv || resp_data !== m_rd) begin errors++; $display("FAIL wrap_resp: got %b/%h want %b/%h", resp_valid, resp_data, m_rv, m_rd); end
        advance();
        eval(); advance();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] hist [$];
        req_valid = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            if (c < 6) set_addr(1, AW'($urandom_range(31)));
            else req_valid = '0;
            eval();
            if (c < 6) begin
                hist.push_back(lane_addr(1));
                checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_ready c%0d: got %b want 0010", c, req_ready); end
            end
            if (c >= 2) begin
                logic [AW-1:0] a;
                a = hist.pop_front();
                checks++; if (resp_valid !== 4'b0010 || resp_data[DW +: DW] !== rom[a]) begin
                    errors++; $display("FAIL b2b_resp c%0d: got v=%b d=%h want v=0010 d=%h", c, resp_valid, resp_data[DW +: DW], rom[a]);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [N-1:0] took;
        for (int l = 0; l < N; l++) set_addr(l, AW'($urandom_range(31)));
        req_valid = '0;
        for (int c = 0; c < 300; c++) begin
            eval();
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
            checks++; if (lut_en !== exp_en || lut_addr_a !== exp_aa || lut_addr_b !== exp_ab) begin
                errors++; $display("FAIL rand_lut c%0d: got %b %0d %0d want %b %0d %0d", c, lut_en, lut_addr_a, lut_addr_b, exp_en, exp_aa, exp_ab);
            end
            checks++; if (resp_valid !== m_rv || resp_data !== m_rd) begin errors++; $display("FAIL rand_resp c%0d: got %b/%h want %b/%h", c, resp_valid, resp_data, m_rv, m_rd); end
            checks++; if (grant_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL rand_grant_cnt c%0d: got %0d want %0d", c, grant_cnt, m_cnt); end
            took = exp_ready;
            advance();
            // Lanes hold their request until it transfers.
            for (int l = 0; l < N; l++) begin
                if (took[l] || !req_valid[l]) begin
                    req_valid[l] = ($urandom_range(99) < 60);
                    set_addr(l, AW'($urandom_range(31)));
                end
            end
        end
        req_valid = '0;
        eval(); advance();
        eval(); advance();
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        eval(); advance();
        rst = 1'b0;
        req_valid = '1;
        for (int c = 0; c < 32767; c++) begin
            eval(); advance();
        end
        eval();
        checks++; if (grant_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want fffe", grant_cnt); end
        advance();
        eval();
        checks++; if (grant_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h want ffff", grant_cnt); end
        advance();
        eval();
        checks++; if (grant_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want ffff", grant_cnt); end
        advance();
        req_valid = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = DW'($urandom);
        rom[16] = 20'h0160C;
        rom[0]  = 20'h00267;
        rom[31] = 20'h00004;
        req_addr = '0;
        test_reset();
        test_single();
        test_dual();
        test_fairness();
        test_reset_midflight();
        test_wrap();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
